// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and constants for the programmable clock divider controller.
//   state_e   : controller FSM state (IDLE / PENDING)
//   CLK_IN_HZ : nominal input clock frequency
//   DIV_60HZ  : divisor giving ~60 Hz from CLK_IN_HZ
//   DIV_MIN   : smallest divisor the controller will accept
// -----------------------------------------------------------------------------
package clk_div_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    localparam int unsigned CLK_IN_HZ = 4_000_000;
    localparam int unsigned DIV_60HZ  = 66666;
    localparam int unsigned DIV_MIN   = 2;

endpackage : clk_div_pkg

// File: rtl/div_counter.sv
// -----------------------------------------------------------------------------
// div_counter
// Divide counter holding the active divisor. Counts 0 .. div-1 while enabled,
// is parked at 0 while disabled, and takes a new divisor on load (which also
// restarts the period at 0).
// Ports:
//   clk_in     : system clock
//   rst        : synchronous active-high reset
//   en         : run enable; low forces the count to 0 on the next edge
//   load       : replace the active divisor with load_div, restart period
//   load_div   : divisor to load
//   tick       : high on the last cycle of each period (only while en)
//   clk_out    : divided clock, low for floor(div/2), high for ceil(div/2)
//   active_div : divisor currently in use
// -----------------------------------------------------------------------------
module div_counter #(
    parameter int unsigned WIDTH       = 19,
    parameter int unsigned DIV_DEFAULT = 66666
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    output logic             tick,
    output logic             clk_out,
    output logic [WIDTH-1:0] active_div
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] div_q,   div_d;
    logic [WIDTH-1:0] last_count;

    // div_q is always >= 2, so div_q - 1 cannot wrap.
    assign last_count = div_q - WIDTH'(1);
    assign tick       = en && (count_q == last_count);
    // Pure decode of registered state; the half-period threshold is a shift.
    assign clk_out    = (count_q >= (div_q >> 1));
    assign active_div = div_q;

    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        if (load) begin
            div_d   = load_div;
            count_d = '0;
        end else if (!en) begin
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            count_q <= '0;
            div_q   <= WIDTH'(DIV_DEFAULT);
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

endmodule : div_counter

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time controller for the programmable clock divider. Accepts new divisors
// over a valid/ready handshake, rejects divisors below DIV_MIN, and applies an
// accepted divisor only at a period boundary so clk_out never glitches.
// Ports:
//   clk_in     : system clock
//   rst        : synchronous active-high reset
//   en         : run enable; low stops and holds the divider at count 0
//   cfg_div    : requested divisor
//   cfg_valid  : request valid
//   cfg_ready  : controller can accept a request (IDLE and not in reset)
//   cfg_err    : one-cycle pulse, the cycle after a rejected request
//   clk_out    : divided clock
//   tick       : one-cycle pulse on the last cycle of each period
//   active_div : divisor currently in use
//   busy       : an accepted divisor is waiting for the period boundary
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int unsigned WIDTH       = 19,
    parameter int unsigned DIV_DEFAULT = clk_div_pkg::DIV_60HZ,
    parameter int unsigned DIV_MIN     = clk_div_pkg::DIV_MIN
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] active_div,
    output logic             busy
);

    import clk_div_pkg::*;

    localparam logic [WIDTH-1:0] DIV_MIN_W = WIDTH'(DIV_MIN);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pend_q,  pend_d;
    logic             err_q,   err_d;
    logic             load;

    // Apply on the wrap cycle; when disabled the counter is already parked
    // at 0, so the pending value can go in on the very next edge.
    assign load      = (state_q == PENDING) && (tick || !en);
    assign cfg_ready = !rst && (state_q == IDLE);
    assign busy      = (state_q == PENDING);
    assign cfg_err   = err_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (cfg_div < DIV_MIN_W) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d  = cfg_div;
                        state_d = PENDING;
                    end
                end
            end
            PENDING: begin
                if (load) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    div_counter #(
        .WIDTH       (WIDTH),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_div_counter (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .load_div   (pend_q),
        .tick       (tick),
        .clk_out    (clk_out),
        .active_div (active_div)
    );

endmodule : clk_div_ctrl

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Directed self-checking bench for clk_div_ctrl with DIV_DEFAULT = 10.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

    localparam int unsigned W = 19;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] cfg_div;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] active_div;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    clk_div_ctrl #(
        .WIDTH       (W),
        .DIV_DEFAULT (10),
        .DIV_MIN     (2)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .cfg_div    (cfg_div),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .clk_out    (clk_out),
        .tick       (tick),
        .active_div (active_div),
        .busy       (busy)
    );

    // Waits for a tick (count == D-1); leaves the caller at that falling edge.
    task automatic wait_tick(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk_in);
            if (tick === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_tick_timeout: got no tick, required tick within 40 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_div = '0;
        repeat (3) @(negedge clk_in);
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b required 0", cfg_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_vec++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL rst_clk_out: got %b required 0", clk_out); end
        n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b required 0", tick); end
        n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", cfg_err); end
        n_vec++; if (active_div !== W'(10)) begin n_err++; $display("FAIL rst_div: got %0d required 10", active_div); end
        rst = 1'b0;
        #1;
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b required 1", cfg_ready); end
        // Count is 0 in the release cycle; following samples see counts 1, 2, ...
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            n_vec++; if (clk_out !== ((k % 10) >= 5)) begin n_err++; $display("FAIL d10_clk_out k=%0d: got %b required %b", k, clk_out, ((k % 10) >= 5)); end
            n_vec++; if (tick !== ((k % 10) == 9)) begin n_err++; $display("FAIL d10_tick k=%0d: got %b required %b", k, tick, ((k % 10) == 9)); end
        end
        $display("test_reset: done, %0d miscompares so far", n_err);
    endtask

    task automatic test_reject();
        cfg_valid = 1'b1; cfg_div = W'(1);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL rej1_err: got %b required 1", cfg_err); end
        n_vec++; if (active_div !== W'(10)) begin n_err++; $display("FAIL rej1_div: got %0d required 10", active_div); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rej1_ready: got %b required 1", cfg_ready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rej1_busy: got %b required 0", busy); end
        @(negedge clk_in);
        n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rej1_err_drop: got %b required 0", cfg_err); end
        cfg_valid = 1'b1; cfg_div = W'(0);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        n_vec++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL rej0_err: got %b required 1", cfg_err); end
        @(negedge clk_in);
        n_vec++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL rej0_err_drop: got %b required 0", cfg_err); end
        n_vec++; if (active_div !== W'(10)) begin n_err++; $display("FAIL rej0_div: got %0d required 10", active_div); end
        $display("test_reject: done, %0d miscompares so far", n_err);
    endtask

    task automatic test_disable();
        wait_tick("dis");
        repeat (7) @(negedge clk_in);   // count = 6
        n_vec++; if (clk_out !== 1'b1) begin n_err++; $display("FAIL dis_pre_clk_out: got %b required 1", clk_out); end
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            n_vec++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL dis_clk_out k=%0d: got %b required 0", k, clk_out); end
            n_vec++; if (tick !== 1'b0) begin n_err++; $display("FAIL dis_tick k=%0d: got %b required 0", k, tick); end
        end
        // Same-as-current divisor while disabled: normal PENDING path, one cycle.
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL dis_ready: got %b required 1", cfg_ready); end
        cfg_valid = 1'b1; cfg_div = W'(10);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL dis_busy: got %b required 1", busy); end
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL dis_ready_low: got %b required 0", cfg_ready); end
        @(negedge clk_in);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL dis_applied_busy: got %b required 0", busy); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL dis_applied_ready: got %b required 1", cfg_ready); end
        n_vec++; if (active_div !== W'(10)) begin n_err++; $display("FAIL dis_applied_div: got %0d required 10", active_div); end
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in);
            n_vec++; if (clk_out !== ((k % 10) >= 5)) begin n_err++; $display("FAIL reen_clk_out k=%0d: got %b required %b", k, clk_out, ((k % 10) >= 5)); end
            n_vec++; if (tick !== ((k % 10) == 9)) begin n_err++; $display("FAIL reen_tick k=%0d: got %b required %b", k, tick, ((k % 10) == 9)); end
        end
        $display("test_disable: done, %0d miscompares so far", n_err);
    endtask

    task automatic test_change();
        wait_tick("chg");
        repeat (3) @(negedge clk_in);   // count = 2
        cfg_valid = 1'b1; cfg_div = W'(7);
        // Busy from count 3 through the wrap at count 9: 7 cycles.
        for (int k = 3; k <= 9; k++) begin
            @(negedge clk_in);
            cfg_valid = 1'b0;
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL chg_busy k=%0d: got %b required 1", k, busy); end
            n_vec++; if (active_div !== W'(10)) begin n_err++; $display("FAIL chg_old_div k=%0d: got %0d required 10", k, active_div); end
            n_vec++; if (tick !== (k == 9)) begin n_err++; $display("FAIL chg_tick k=%0d: got %b required %b", k, tick, (k == 9)); end
        end
        @(negedge clk_in);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL chg_busy_drop: got %b required 0", busy); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL chg_ready: got %b required 1", cfg_ready); end
        n_vec++; if (active_div !== W'(7)) begin n_err++; $display("FAIL chg_new_div: got %0d required 7", active_div); end
        n_vec++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL chg_clk_out k=0: got %b required 0", clk_out); end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk_in);
            n_vec++; if (clk_out !== ((k % 7) >= 3)) begin n_err++; $display("FAIL d7_clk_out k=%0d: got %b required %b", k, clk_out, ((k % 7) >= 3)); end
            n_vec++; if (tick !== ((k % 7) == 6)) begin n_err++; $display("FAIL d7_tick k=%0d: got %b required %b", k, tick, ((k % 7) == 6)); end
        end
        $display("test_change: done, %0d miscompares so far", n_err);
    endtask

    task automatic test_reset_pending();
        cfg_valid = 1'b1; cfg_div = W'(4);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rp_busy: got %b required 1", busy); end
        rst = 1'b1;
        @(negedge clk_in);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rp_rst_busy: got %b required 0", busy); end
        n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rp_rst_ready: got %b required 0", cfg_ready); end
        n_vec++; if (active_div !== W'(10)) begin n_err++; $display("FAIL rp_rst_div: got %0d required 10", active_div); end
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in);
            n_vec++; if (active_div !== W'(10)) begin n_err++; $display("FAIL rp_div k=%0d: got %0d required 10", k, active_div); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rp_busy_after k=%0d: got %b required 0", k, busy); end
            n_vec++; if (clk_out !== ((k % 10) >= 5)) begin n_err++; $display("FAIL rp_clk_out k=%0d: got %b required %b", k, clk_out, ((k % 10) >= 5)); end
            n_vec++; if (tick !== ((k % 10) == 9)) begin n_err++; $display("FAIL rp_tick k=%0d: got %b required %b", k, tick, ((k % 10) == 9)); end
        end
        $display("test_reset_pending: done, %0d miscompares so far", n_err);
    endtask

    task automatic test_back_to_back();
        bit rose = 1'b0;
        bit done = 1'b0;
        cfg_valid = 1'b1; cfg_div = W'(6);
        @(negedge clk_in);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b required 1", busy); end
        cfg_div = W'(3);
        for (int i = 0; i < 30 && !rose; i++) begin
            @(negedge clk_in);
            if (cfg_ready === 1'b1) begin
                rose = 1'b1;
            end else begin
                n_vec++; if (active_div !== W'(10)) begin n_err++; $display("FAIL b2b_hold_div: got %0d required 10", active_div); end
                cfg_div = (cfg_div == W'(3)) ? W'(6) : W'(3);
            end
        end
        n_vec++; if (!rose) begin n_err++; $display("FAIL b2b_ready_timeout: got ready 0, required ready within 30 cycles"); end
        n_vec++; if (active_div !== W'(6)) begin n_err++; $display("FAIL b2b_first_div: got %0d required 6", active_div); end
        cfg_div = W'(9);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_second_busy: got %b required 1", busy); end
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk_in);
            if (busy === 1'b0) done = 1'b1;
        end
        n_vec++; if (!done) begin n_err++; $display("FAIL b2b_apply_timeout: got busy 1, required busy 0 within 30 cycles"); end
        n_vec++; if (active_div !== W'(9)) begin n_err++; $display("FAIL b2b_second_div: got %0d required 9", active_div); end
        $display("test_back_to_back: done, %0d miscompares so far", n_err);
    endtask

    initial begin
        test_reset();
        test_reject();
        test_disable();
        test_change();
        test_reset_pending();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_clk_div_ctrl

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time controller for the board's programmable clock divider (4 MHz `clk_in`; default output 60 Hz).
- Owns the divide counter and generates `clk_out` plus a one-cycle `tick` per output period.
- Accepts new divisor values over a valid/ready handshake and applies them only at a period boundary, so `clk_out` never glitches.
- Sits between the user-logic configuration source (switch decoder or sequencer) and the display/timing logic that consumes `clk_out`/`tick`.

Parameters:
- `WIDTH`, 19: divisor and counter width in bits.
- `DIV_DEFAULT`, 66666: divisor loaded at reset (4 MHz / 66666 ≈ 60 Hz). Must fit in `WIDTH`.
- `DIV_MIN`, 2: smallest divisor accepted; smaller requests are rejected.

Ports:
- `clk_in` in 1: single system clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable. Low stops and holds the divider.
- `cfg_div` in WIDTH: requested divisor.
- `cfg_valid` in 1: request valid.
- `cfg_ready` out 1: controller can accept a request.
- `cfg_err` out 1: one-cycle pulse when a request is rejected.
- `clk_out` out 1: divided clock.
- `tick` out 1: one-cycle pulse on the last cycle of each period.
- `active_div` out WIDTH: divisor currently in use.
- `busy` out 1: a request is pending (state `PENDING`).

Behaviour:
- One clock (`clk_in`); reset is synchronous and active-high (`rst`). All state updates on `posedge clk_in`.
- Reset values:
  - `count` = 0, `active_div` = `DIV_DEFAULT`, pending register = 0.
  - State = `IDLE`.
  - `clk_out` = 0, `tick` = 0, `cfg_err` = 0, `busy` = 0.
  - `cfg_ready` = 0 while `rst` is high, 1 on the first cycle after.
- Counter (`en` = 1):
  - Counts 0 .. `active_div` − 1, then wraps to 0.
  - `tick` = 1 combinationally when `count` == `active_div` − 1 and `en` = 1.
- Output clock:
  - `clk_out` = 1 when `count` >= (`active_div` >> 1), else 0. Combinational from registered `count`/`active_div`, decode only, no new logic levels on the counter path.
  - Odd divisor: low phase is floor(D/2) cycles, high phase is ceil(D/2).
- `en` = 0: `count` is forced to 0 on the next edge, so `clk_out` = 0 and `tick` = 0. Re-asserting `en` starts a fresh period with the low phase.
- FSM `IDLE`:
  - `cfg_ready` = 1.
  - On `cfg_valid` with `cfg_div` < `DIV_MIN`: `cfg_err` pulses for 1 cycle; state stays `IDLE`; `active_div` unchanged.
  - On `cfg_valid` with a legal `cfg_div`: the value is latched into pending; go to `PENDING`.
- FSM `PENDING`:
  - `cfg_ready` = 0, `busy` = 1. `cfg_valid` is ignored.
  - Leaves on the wrap cycle (`tick` = 1): `active_div` <= pending, `count` <= 0, go to `IDLE`.
  - If `en` = 0 in `PENDING`, the value is applied on the next edge (counter already at 0).
- Latency and boundaries:
  - Accept to apply: (cycles remaining in the current period) + 1.
  - `cfg_ready` returns 1 the cycle after the apply.
  - A request equal to the current divisor is still accepted and goes through the normal `PENDING` path.
  - `rst` during `PENDING` drops the pending value; `active_div` returns to `DIV_DEFAULT`.
  - `rst` has priority over `en` and `cfg_valid`.
- Width rules:
  - All compares are unsigned at `WIDTH` bits. No truncation: the counter is exactly `WIDTH` bits.
  - `active_div` − 1 never underflows because `active_div` >= `DIV_MIN` >= 2.

Decomposition:
- Package `clk_div_pkg`:
  - State encoding `IDLE` = 1'b0, `PENDING` = 1'b1.
  - Constants `CLK_IN_HZ` = 4_000_000, `DIV_60HZ` = 66666, `DIV_MIN` = 2.
- One sub-module, `div_counter`: counter, wrap, `tick` and `clk_out` compare. Inputs: `clk_in`, `rst`, `en`, `load`, `load_div`. The FSM and handshake stay in `clk_div_ctrl`.

Test Plan:
- Reset with `DIV_DEFAULT` = 10 overridden, `en` = 1 → `clk_out` is low 5 cycles then high 5, `tick` every 10 cycles, `active_div` = 10.
- Request `cfg_div` = 7 at `count` = 3 → `busy` for 7 cycles; the new period starts at `count` = 0 with 3 low / 4 high; `cfg_ready` returns the cycle after the apply.
- Request `cfg_div` = 1 → `cfg_err` = 1 for exactly 1 cycle; `active_div` stays 10; `cfg_ready` stays 1.
- `en` = 0 mid-period at `count` = 6 → next cycle `count` = 0, `clk_out` = 0, no `tick`. A request issued while disabled is applied 1 cycle after acceptance.
- `rst` asserted during `PENDING` (pending = 4) → after release `active_div` = 10, `busy` = 0, `count` = 0.
- `cfg_valid` held high with alternating values while `busy` → only the first value is applied, and a second request is accepted only after `cfg_ready` rises.
